// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reset_sequencer                                               |
// | Brief    : Qualifies PLL lock, then releases per-domain resets in order. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int LOCK_FILTER = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pll_locked,
  input  logic                  i_sw_rst,
  output logic [NUM_STAGES-1:0] o_rst_n,
  output logic                  o_busy,
  output logic                  o_lock_lost
);

  localparam int c_fcnt_w = $clog2(LOCK_FILTER + 1);
  localparam int c_hcnt_w = $clog2(HOLD_CYCLES + 1);
  localparam int c_gcnt_w = $clog2(STAGE_GAP + 1);

  localparam logic [c_fcnt_w-1:0] c_fcnt_max  = c_fcnt_w'(LOCK_FILTER);
  localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(LOCK_FILTER - 1);
  localparam logic [c_hcnt_w-1:0] c_hcnt_max  = c_hcnt_w'(HOLD_CYCLES);
  localparam logic [c_hcnt_w-1:0] c_hcnt_last = c_hcnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_gcnt_w-1:0] c_gcnt_max  = c_gcnt_w'(STAGE_GAP);
  localparam logic [c_gcnt_w-1:0] c_gcnt_last = c_gcnt_w'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_lock_meta;
  logic                  r_lock_s;
  logic [c_fcnt_w-1:0]   r_fcnt;
  logic [c_hcnt_w-1:0]   r_hcnt;
  logic [c_gcnt_w-1:0]   r_gcnt;
  logic [NUM_STAGES-1:0] r_rst_n;
  logic                  r_busy;
  logic                  r_lock_lost;

  logic [NUM_STAGES-1:0] w_rst_next;
  logic                  w_armed;
  logic                  w_lock_drop;

  // Releases form a thermometer code, so the next pattern shifts in one more '1'.
  assign w_rst_next  = NUM_STAGES'({r_rst_n, 1'b1});
  assign w_armed     = (r_state != ST_WAIT_LOCK);
  assign w_lock_drop = w_armed && !r_lock_s;

  assign o_rst_n     = r_rst_n;
  assign o_busy      = r_busy;
  assign o_lock_lost = r_lock_lost;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_WAIT_LOCK;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_fcnt      <= '0;
      r_hcnt      <= '0;
      r_gcnt      <= '0;
      r_rst_n     <= '0;
      r_busy      <= 1'b1;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_locked;
      r_lock_s    <= r_lock_meta;
      r_lock_lost <= 1'b0;

      // Aborts win over normal progression, so no release can share an edge with one.
      if (i_sw_rst || w_lock_drop) begin
        r_state     <= ST_WAIT_LOCK;
        r_rst_n     <= '0;
        r_busy      <= 1'b1;
        r_fcnt      <= '0;
        r_lock_lost <= w_lock_drop;
      end else begin
        case (r_state)
          ST_WAIT_LOCK: begin
            if (!r_lock_s) begin
              r_fcnt <= '0;
            end else begin
              if (r_fcnt != c_fcnt_max) begin
                r_fcnt <= r_fcnt + 1'b1;
              end
              if (r_fcnt == c_fcnt_last) begin
                r_state <= ST_HOLD;
                r_hcnt  <= '0;
              end
            end
          end

          ST_HOLD: begin
            if (r_hcnt == c_hcnt_last) begin
              r_rst_n <= w_rst_next;
              r_gcnt  <= '0;
              if (&w_rst_next) begin
                r_busy  <= 1'b0;
                r_state <= ST_RUN;
              end else begin
                r_state <= ST_RELEASE;
              end
            end else if (r_hcnt != c_hcnt_max) begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end

          ST_RELEASE: begin
            if (r_gcnt == c_gcnt_last) begin
              r_rst_n <= w_rst_next;
              r_gcnt  <= '0;
              if (&w_rst_next) begin
                r_busy  <= 1'b0;
                r_state <= ST_RUN;
              end
            end else if (r_gcnt != c_gcnt_max) begin
              r_gcnt <= r_gcnt + 1'b1;
            end
          end

          ST_RUN: begin
            r_busy <= 1'b0;
          end

          default: begin
            r_state <= ST_WAIT_LOCK;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
            r_fcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
